// File: rtl/forwarding_controller_if.sv
// Handshake bundle between the ID stage and the EX-stage forwarding controller.
// The pipeline side drives the ID instruction fields; the controller returns mux selects and stall status.
interface forwarding_controller_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              hold;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_reg;
    logic              id_is_load;
    logic [3:0]        redirection_ctrl;
    logic              stall;
    logic              ex_bubble;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load,
        input  redirection_ctrl, stall, ex_bubble, stall_count
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load,
        output redirection_ctrl, stall, ex_bubble, stall_count
    );
endinterface

// File: rtl/forwarding_controller.sv
// EX-stage operand forwarding controller: tracks EX/MEM destination records,
// registers the redirection mux selects and detects load-use hazards.
module forwarding_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    forwarding_controller_if.slave fc
);
    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } rec_t;

    localparam rec_t REC_NONE = '{valid: 1'b0, wr_en: 1'b0, dest: {REG_AW{1'b0}}, is_load: 1'b0};

    rec_t             ex_q, ex_d;
    rec_t             mem_q, mem_d;
    rec_t             id_rec_s;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             bubble_q, bubble_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_s;
    logic             id_rec_valid_s;
    logic             mx_rs_s, mx_rt_s, mm_rs_s, mm_rt_s;
    logic [1:0]       sel_a_s, sel_b_s;

    // Register 0 is hardwired, so a write to it never counts as a producer.
    function automatic logic reg_match(input rec_t rec, input logic [REG_AW-1:0] r);
        return rec.valid & rec.wr_en & (rec.dest == r) & (r != {REG_AW{1'b0}});
    endfunction

    // Producer matches against EX and MEM records, and the load-use stall
    always_comb begin
        mx_rs_s = reg_match(ex_q, fc.id_rs);
        mx_rt_s = reg_match(ex_q, fc.id_rt);
        mm_rs_s = reg_match(mem_q, fc.id_rs);
        mm_rt_s = reg_match(mem_q, fc.id_rt);
        stall_s = fc.id_valid & ~fc.flush & ex_q.is_load &
                  ((fc.id_use_rs & mx_rs_s) | (fc.id_use_rt & mx_rt_s));
        id_rec_valid_s = fc.id_valid & ~fc.flush & ~stall_s;
    end

    // Operand select per source: the EX producer is newer and wins over MEM
    always_comb begin
        sel_a_s = 2'b00;
        sel_b_s = 2'b00;
        if (fc.id_use_rs & mx_rs_s) begin
            sel_a_s = 2'b01;
        end else if (fc.id_use_rs & mm_rs_s) begin
            sel_a_s = 2'b10;
        end else begin
            sel_a_s = 2'b00;
        end
        if (fc.id_use_rt & mx_rt_s) begin
            sel_b_s = 2'b01;
        end else if (fc.id_use_rt & mm_rt_s) begin
            sel_b_s = 2'b10;
        end else begin
            sel_b_s = 2'b00;
        end
    end

    // Next-state for pipeline records, selects, bubble flag and stall counter
    always_comb begin
        id_rec_s = REC_NONE;
        ex_d     = ex_q;
        mem_d    = mem_q;
        ctrl_d   = ctrl_q;
        bubble_d = bubble_q;
        count_d  = count_q;
        if (id_rec_valid_s) begin
            id_rec_s = '{valid: 1'b1, wr_en: fc.id_wr_en, dest: fc.id_wr_reg, is_load: fc.id_is_load};
        end else begin
            id_rec_s = REC_NONE;
        end
        if (!fc.hold) begin
            mem_d    = ex_q;
            ex_d     = id_rec_s;
            bubble_d = stall_s | fc.flush | ~fc.id_valid;
            if (id_rec_valid_s) begin
                ctrl_d = {sel_b_s, sel_a_s};
            end else begin
                ctrl_d = 4'b0000;
            end
            if (stall_s && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q     <= REC_NONE;
            mem_q    <= REC_NONE;
            ctrl_q   <= 4'b0000;
            bubble_q <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
            count_q  <= count_d;
        end
    end

    assign fc.redirection_ctrl = ctrl_q;
    assign fc.stall            = stall_s;
    assign fc.ex_bubble        = bubble_q;
    assign fc.stall_count      = count_q;
endmodule

// File: tb/tb_forwarding_controller.sv
// Directed testbench for forwarding_controller; CNT_W is shrunk so saturation is reachable.
module tb_forwarding_controller;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [CNT_W-1:0] exp_count;

    forwarding_controller_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) fc_if ();

    forwarding_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fc    (fc_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] wr, input logic ld);
        fc_if.id_valid   = v;
        fc_if.id_rs      = rs;
        fc_if.id_rt      = rt;
        fc_if.id_use_rs  = urs;
        fc_if.id_use_rt  = urt;
        fc_if.id_wr_en   = we;
        fc_if.id_wr_reg  = wr;
        fc_if.id_is_load = ld;
    endtask

    task automatic idle();
        fc_if.hold  = 1'b0;
        fc_if.flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fc_if.hold  = 1'b0;
        fc_if.flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000) $display("FAIL reset_ctrl got=%b exp=0000", fc_if.redirection_ctrl);
        else n_pass++;
        n_checks++;
        if (fc_if.ex_bubble !== 1'b0) $display("FAIL reset_bubble got=%b exp=0", fc_if.ex_bubble);
        else n_pass++;
        n_checks++;
        if (fc_if.stall_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", fc_if.stall_count);
        else n_pass++;
        rst_n = 1'b1;
        exp_count = 4'd0;
    endtask

    task automatic test_ex_forward();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
        step();
        set_id(1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        #1;
        n_checks++;
        if (fc_if.stall !== 1'b0) $display("FAIL ex_fwd_stall got=%b exp=0", fc_if.stall);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0001) $display("FAIL ex_fwd_ctrl got=%b exp=0001", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    task automatic test_mem_forward();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        step();
        set_id(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0110) $display("FAIL mem_fwd_ctrl got=%b exp=0110", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    task automatic test_ex_priority();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0);
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0100) $display("FAIL ex_priority_ctrl got=%b exp=0100", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
        #1;
        n_checks++;
        if (fc_if.stall !== 1'b1) $display("FAIL load_use_stall got=%b exp=1", fc_if.stall);
        else n_pass++;
        step();
        exp_count = exp_count + 4'd1;
        n_checks++;
        if (fc_if.ex_bubble !== 1'b1) $display("FAIL load_use_bubble got=%b exp=1", fc_if.ex_bubble);
        else n_pass++;
        n_checks++;
        if (fc_if.stall_count !== exp_count) $display("FAIL load_use_count got=%0d exp=%0d", fc_if.stall_count, exp_count);
        else n_pass++;
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000) $display("FAIL load_use_bubble_ctrl got=%b exp=0000", fc_if.redirection_ctrl);
        else n_pass++;
        n_checks++;
        if (fc_if.stall !== 1'b0) $display("FAIL load_use_restall got=%b exp=0", fc_if.stall);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0010) $display("FAIL load_use_memfwd got=%b exp=0010", fc_if.redirection_ctrl);
        else n_pass++;
        n_checks++;
        if (fc_if.ex_bubble !== 1'b0) $display("FAIL load_use_bubble_clr got=%b exp=0", fc_if.ex_bubble);
        else n_pass++;
    endtask

    task automatic test_flush();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        step();
        set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
        fc_if.flush = 1'b1;
        #1;
        n_checks++;
        if (fc_if.stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", fc_if.stall);
        else n_pass++;
        step();
        fc_if.flush = 1'b0;
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000) $display("FAIL flush_ctrl got=%b exp=0000", fc_if.redirection_ctrl);
        else n_pass++;
        n_checks++;
        if (fc_if.ex_bubble !== 1'b1) $display("FAIL flush_bubble got=%b exp=1", fc_if.ex_bubble);
        else n_pass++;
        n_checks++;
        if (fc_if.stall_count !== exp_count) $display("FAIL flush_count got=%0d exp=%0d", fc_if.stall_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_r0();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        #1;
        n_checks++;
        if (fc_if.stall !== 1'b0) $display("FAIL r0_stall got=%b exp=0", fc_if.stall);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000) $display("FAIL r0_ctrl got=%b exp=0000", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    task automatic test_hold();
        idle();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1);
        step();
        set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
        fc_if.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fc_if.stall !== 1'b1 || fc_if.ex_bubble !== 1'b0 || fc_if.redirection_ctrl !== 4'b0000 ||
                fc_if.stall_count !== exp_count)
                $display("FAIL hold_frozen cyc=%0d got stall=%b bub=%b ctrl=%b cnt=%0d exp stall=1 bub=0 ctrl=0000 cnt=%0d",
                         i, fc_if.stall, fc_if.ex_bubble, fc_if.redirection_ctrl, fc_if.stall_count, exp_count);
            else n_pass++;
        end
        fc_if.hold = 1'b0;
        step();
        exp_count = exp_count + 4'd1;
        n_checks++;
        if (fc_if.stall_count !== exp_count || fc_if.ex_bubble !== 1'b1)
            $display("FAIL hold_release got cnt=%0d bub=%b exp cnt=%0d bub=1", fc_if.stall_count, fc_if.ex_bubble, exp_count);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0010) $display("FAIL hold_memfwd got=%b exp=0010", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int guard;
        idle();
        set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1);
        guard = 0;
        while (fc_if.stall_count != 4'hF && guard < 80) begin
            step();
            guard++;
        end
        n_checks++;
        if (fc_if.stall_count !== 4'hF) $display("FAIL sat_reach got=%0d exp=15", fc_if.stall_count);
        else n_pass++;
        guard = 0;
        while (fc_if.stall !== 1'b1 && guard < 4) begin
            step();
            guard++;
        end
        n_checks++;
        if (fc_if.stall !== 1'b1) $display("FAIL sat_stall got=%b exp=1", fc_if.stall);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.stall_count !== 4'hF) $display("FAIL sat_hold got=%0d exp=15", fc_if.stall_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        int guard;
        guard = 0;
        while (fc_if.stall !== 1'b1 && guard < 4) begin
            step();
            guard++;
        end
        n_checks++;
        if (fc_if.stall !== 1'b1) $display("FAIL rst_mid_prestall got=%b exp=1", fc_if.stall);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000 || fc_if.ex_bubble !== 1'b0 || fc_if.stall_count !== 4'd0)
            $display("FAIL rst_mid_clear got ctrl=%b bub=%b cnt=%0d exp ctrl=0000 bub=0 cnt=0",
                     fc_if.redirection_ctrl, fc_if.ex_bubble, fc_if.stall_count);
        else n_pass++;
        rst_n = 1'b1;
        set_id(1'b1, 5'd11, 5'd11, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
        #1;
        n_checks++;
        if (fc_if.stall !== 1'b0) $display("FAIL rst_mid_stall got=%b exp=0", fc_if.stall);
        else n_pass++;
        step();
        n_checks++;
        if (fc_if.redirection_ctrl !== 4'b0000) $display("FAIL rst_mid_ctrl got=%b exp=0000", fc_if.redirection_ctrl);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_count = 4'd0;
        rst_n     = 1'b0;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_ex_priority();
        test_load_use();
        test_flush();
        test_r0();
        test_hold();
        test_saturate();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
